// File: rtl/arm_core_pkg.sv
// Shared definitions for the register-file write-back path.
//   REG_W       : register data width
//   REG_N       : number of architectural registers
//   SP_XZR_IDX  : register index shared by SP and XZR
//   wb_req_t    : one pending register write {rd, data, sp}
//   wb_commits  : true when a request really updates the file
//                 (false for rd == 31 without the SP flag, which targets XZR)
package arm_core_pkg;

  localparam int         REG_W      = 64;
  localparam int         REG_N      = 32;
  localparam logic [4:0] SP_XZR_IDX = 5'd31;

  typedef struct packed {
    logic [4:0]       rd;
    logic [REG_W-1:0] data;
    logic             sp;
  } wb_req_t;

  function automatic logic wb_commits(input wb_req_t req);
    return !((req.rd == SP_XZR_IDX) && !req.sp);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : enqueue din (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   dout       : current head entry (valid while !empty)
//   full/empty : occupancy flags
module wb_fifo
  import arm_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits are equal.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; emptiness is defined by
  // the pointers alone, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-side controller for the 32x64 register file.
// Merges load returns (highest priority) and ALU results (queued, FIFO order)
// onto the single write port, and keeps a scoreboard of registers awaiting
// load data so the issue stage can stall on them.
// Ports:
//   clk, rst_n                           : clock, asynchronous active-low reset
//   alu_valid/alu_ready                  : ALU result handshake
//   alu_rd, alu_data, alu_sp             : ALU destination, result, SP-vs-XZR flag
//   ld_valid, ld_rd, ld_data, ld_sp      : load return (always accepted)
//   ld_issue, ld_issue_rd                : load issued this cycle and its destination
//   rf_we, rf_waddr, rf_wdata            : registered register-file write port
//   busy                                 : per-register outstanding-load bits
//   idle                                 : queue empty and no outstanding loads
//   sb_err                               : sticky scoreboard protocol error
// Data width and register count come from arm_core_pkg.
module reg_wb_ctrl
  import arm_core_pkg::*;
#(
  parameter int ALU_Q_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [REG_W-1:0] alu_data,
  input  logic             alu_sp,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [REG_W-1:0] ld_data,
  input  logic             ld_sp,
  input  logic             ld_issue,
  input  logic [4:0]       ld_issue_rd,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [REG_W-1:0] rf_wdata,
  output logic [REG_N-1:0] busy,
  output logic             idle,
  output logic             sb_err
);

  localparam logic [REG_N-1:0] ONE_HOT_0 = {{(REG_N-1){1'b0}}, 1'b1};

  wb_req_t alu_req;
  wb_req_t ld_req;
  wb_req_t q_head;
  wb_req_t sel;
  logic    sel_valid;

  logic q_full;
  logic q_empty;
  logic q_push;
  logic q_pop;
  logic alu_acc;
  logic bypass;

  logic [REG_N-1:0] set_vec;
  logic [REG_N-1:0] clr_vec;
  logic             err_now;

  assign alu_req = '{rd: alu_rd, data: alu_data, sp: alu_sp};
  assign ld_req  = '{rd: ld_rd,  data: ld_data,  sp: ld_sp};

  // Ready depends on queue state only, so the ALU never sees a combinational
  // path from the load return.
  assign alu_ready = !q_full;
  assign alu_acc   = alu_valid && alu_ready;

  // Loads win the port; otherwise the oldest queued ALU result drains; an ALU
  // result skips the queue only when nothing older is waiting.
  assign q_pop  = !ld_valid && !q_empty;
  assign bypass = !ld_valid && q_empty && alu_acc;
  assign q_push = alu_acc && !bypass;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    if (ld_valid) begin
      sel       = ld_req;
      sel_valid = 1'b1;
    end else if (!q_empty) begin
      sel       = q_head;
      sel_valid = 1'b1;
    end else if (alu_acc) begin
      sel       = alu_req;
      sel_valid = 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (ALU_Q_DEPTH)
  ) u_alu_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (alu_req),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Scoreboard updates. Index 31 is never tracked, so busy[31] stays 0 and
  // the set/clear vectors exclude it.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (ld_issue && (ld_issue_rd != SP_XZR_IDX)) set_vec = ONE_HOT_0 << ld_issue_rd;
    if (ld_valid && (ld_rd != SP_XZR_IDX))       clr_vec = ONE_HOT_0 << ld_rd;
  end

  always_comb begin
    err_now = 1'b0;
    // Re-issue to a busy register is legal only if its return lands this cycle.
    if (ld_issue && (ld_issue_rd != SP_XZR_IDX) && busy[ld_issue_rd] &&
        !(ld_valid && (ld_rd == ld_issue_rd)))
      err_now = 1'b1;
    // A return nobody was waiting for.
    if (ld_valid && (ld_rd != SP_XZR_IDX) && !busy[ld_rd])
      err_now = 1'b1;
    // An ALU result racing an outstanding load to the same register.
    if (alu_acc && (alu_rd != SP_XZR_IDX) && busy[alu_rd])
      err_now = 1'b1;
  end

  assign idle = q_empty && (busy == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
      sb_err   <= 1'b0;
    end else begin
      rf_we    <= sel_valid && wb_commits(sel);
      rf_waddr <= sel.rd;
      rf_wdata <= sel.data;
      // Clear first, then set, so a same-cycle set wins.
      busy     <= (busy & ~clr_vec) | set_vec;
      sb_err   <= sb_err | err_now;
    end
  end

endmodule
